seq_ctrl: RTL and testbench

Stage sequencer for the Y86-64 SEQ processor. Steps one instruction through fetch, decode, execute, memory, writeback and PC-update by driving one-hot stage enables. Owns the condition-code register, loading it from the execute ALU flags on OPq and returning `cnd` for cmovXX/jXX. Stalls the memory stage on a data-memory handshake, raises the processor status, and parks in a sticky halt state on halt, invalid instruction or address error.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/seq_ctrl_if.sv | 36 +++
 rtl/cond_eval.sv | 19 +
 rtl/seq_ctrl.sv | 95 +++++++++
 tb/tb_seq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 instruction codes, status encoding, sequencer states and decode helpers
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {SAOK, SHLT, SADR, SINS} stat_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    function automatic logic is_mem(input logic [3:0] icode);
        return icode inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
    endfunction

    function automatic logic is_invalid(input logic [3:0] icode, input logic [3:0] ifun);
        return icode > IPOPQ ? 1'b1 :
               icode == IOPQ ? ifun > 4'd3 :
               (icode == IRRMOVQ || icode == IJXX) ? ifun > 4'd6 :
               ifun != 4'd0;
    endfunction
endpackage

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: fetch/execute/memory handshake and status bundle between sequencer and datapath
interface seq_ctrl_if #(parameter int CNT_W = 32);
    logic             start;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic             imem_error;
    logic             mem_ready;
    logic             dmem_error;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pc_en;
    logic             mem_req;
    logic [2:0]       cc;
    logic             cnd;
    logic [1:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, icode, ifun, imem_error, mem_ready, dmem_error, alu_zf, alu_sf, alu_of,
        output fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
               mem_req, cc, cnd, stat, busy, retired
    );

    modport slave (
        output start, icode, ifun, imem_error, mem_ready, dmem_error, alu_zf, alu_sf, alu_of,
        input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
               mem_req, cc, cnd, stat, busy, retired
    );
endinterface

// File: rtl/cond_eval.sv
// cond_eval: Y86-64 condition evaluation from {ZF,SF,OF} and the function code
module cond_eval (
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);
    logic zf, lt;

    assign zf  = cc[2];
    assign lt  = cc[1] ^ cc[0];
    assign cnd = ifun == 4'd0 ? 1'b1 :
                 ifun == 4'd1 ? lt | zf :
                 ifun == 4'd2 ? lt :
                 ifun == 4'd3 ? zf :
                 ifun == 4'd4 ? !zf :
                 ifun == 4'd5 ? !lt :
                 ifun == 4'd6 ? !lt & !zf :
                 1'b0;
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: SEQ stage sequencer with instruction register, condition codes and retire counter
module seq_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clock,
    input  logic        reset,
    seq_ctrl_if.master  bus
);
    state_t           state, state_n;
    stat_t            stat_q, stat_n;
    logic [3:0]       ir_icode, ir_ifun;
    logic [2:0]       cc_q;
    logic [CNT_W-1:0] ret_q;
    logic             cond;

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // next state and status; fetch faults use the live fetch inputs, later decisions the IR
    always_comb begin
        state_n = state;
        stat_n  = stat_q;
        case (state)
            S_IDLE:      state_n = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                state_n = S_DECODE;
                if (bus.imem_error) begin
                    state_n = S_HALT;
                    stat_n  = SADR;
                end else if (is_invalid(bus.icode, bus.ifun)) begin
                    state_n = S_HALT;
                    stat_n  = SINS;
                end else if (bus.icode == IHALT) begin
                    state_n = S_HALT;
                    stat_n  = SHLT;
                end
            end
            S_DECODE:    state_n = S_EXECUTE;
            S_EXECUTE:   state_n = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem(ir_icode)) state_n = S_WRITEBACK;
                else if (bus.mem_ready) begin
                    state_n = bus.dmem_error ? S_HALT : S_WRITEBACK;
                    if (bus.dmem_error) stat_n = SADR;
                end
            end
            S_WRITEBACK: state_n = S_PCUPD;
            S_PCUPD:     state_n = S_FETCH;
            default:     state_n = S_HALT;
        endcase
    end

    // instruction register, condition codes, status and retire counter
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_icode <= IHALT;
            ir_ifun  <= 4'd0;
            cc_q     <= 3'b100;
            stat_q   <= SAOK;
            ret_q    <= '0;
        end else begin
            stat_q <= stat_n;
            if (state == S_FETCH) begin
                ir_icode <= bus.icode;
                ir_ifun  <= bus.ifun;
            end
            if (state == S_EXECUTE && ir_icode == IOPQ) cc_q <= {bus.alu_zf, bus.alu_sf, bus.alu_of};
            if (state == S_PCUPD) ret_q <= ret_q + CNT_W'(1);
        end
    end

    cond_eval u_cond (
        .cc   (cc_q),
        .ifun (ir_ifun),
        .cnd  (cond)
    );

    assign bus.fetch_en     = state == S_FETCH;
    assign bus.decode_en    = state == S_DECODE;
    assign bus.execute_en   = state == S_EXECUTE;
    assign bus.memory_en    = state == S_MEMORY;
    assign bus.writeback_en = state == S_WRITEBACK;
    assign bus.pc_en        = state == S_PCUPD;
    assign bus.mem_req      = state == S_MEMORY && is_mem(ir_icode);
    assign bus.cc           = cc_q;
    assign bus.cnd          = (ir_icode == IRRMOVQ || ir_icode == IJXX) && cond;
    assign bus.stat         = stat_q;
    assign bus.busy         = state != S_IDLE && state != S_HALT;
    assign bus.retired      = ret_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: randomized instruction-level check of seq_ctrl against a transaction model
module tb_seq_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;

    seq_ctrl_if #(.CNT_W(32)) bus ();

    seq_ctrl #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [5:0] EN_F = 6'b100000, EN_D = 6'b010000, EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100, EN_W = 6'b000010, EN_P = 6'b000001, EN_Z = 6'b000000;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [2:0]  m_cc = 3'b100;
    logic [31:0] m_ret = 0;
    logic [1:0]  m_stat = 0;
    bit          halted;

    function automatic logic [5:0] en();
        return {bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en, bus.writeback_en, bus.pc_en};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] c);
        logic zf, lt;
        zf = c[2];
        lt = c[1] != c[0];
        if (ic != 4'd2 && ic != 4'd7) return 1'b0;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return lt || zf;
            4'd2: return lt;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !lt;
            4'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] ref_fetch_stat(input logic [3:0] ic, input logic [3:0] fn, input logic ierr);
        logic legal;
        legal = ic <= 4'd11 && ((ic == 4'd6 && fn <= 4'd3) || ((ic == 4'd2 || ic == 4'd7) && fn <= 4'd6) || fn == 4'd0);
        if (ierr) return 2'd2;
        if (!legal) return 2'd3;
        if (ic == 4'd0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic ref_mem(input logic [3:0] ic);
        return ic == 4'd4 || ic == 4'd5 || ic == 4'd8 || ic == 4'd9 || ic == 4'd10 || ic == 4'd11;
    endfunction

    task automatic check_reset_vals();
        check("rst_en", en(), EN_Z);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_cc", bus.cc, 3'b100);
        check("rst_cnd", bus.cnd, 0);
        check("rst_stat", bus.stat, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_retired", bus.retired, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clock);
        check_reset_vals();
        reset = 1'b0;
        m_cc = 3'b100;
        m_ret = 0;
        m_stat = 0;
        halted = 0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic ierr,
                             input int k, input logic derr, input logic [2:0] flags, input bit abort);
        logic [1:0] s;
        logic       mem;
        check("fetch_en", en(), EN_F);
        check("fetch_busy", bus.busy, 1);
        bus.icode = ic;
        bus.ifun = fn;
        bus.imem_error = ierr;
        bus.start = 1'($urandom);
        @(negedge clock);
        bus.imem_error = 1'b0;
        bus.icode = 4'($urandom);
        bus.ifun = 4'($urandom);
        s = ref_fetch_stat(ic, fn, ierr);
        if (s != 2'd0) begin
            m_stat = s;
            halted = 1;
            bus.start = 1'b0;
            check("fault_en", en(), EN_Z);
            check("fault_stat", bus.stat, s);
            check("fault_busy", bus.busy, 0);
            check("fault_retired", bus.retired, m_ret);
            return;
        end
        check("decode_en", en(), EN_D);
        check("decode_cnd", bus.cnd, ref_cnd(ic, fn, m_cc));
        @(negedge clock);
        check("execute_en", en(), EN_E);
        {bus.alu_zf, bus.alu_sf, bus.alu_of} = flags;
        @(negedge clock);
        if (ic == 4'd6) m_cc = flags;
        {bus.alu_zf, bus.alu_sf, bus.alu_of} = 3'($urandom);
        check("memory_cc", bus.cc, m_cc);
        mem = ref_mem(ic);
        if (mem) begin
            for (int w = 0; w <= k; w++) begin
                if (w > 0) @(negedge clock);
                check("memory_en", en(), EN_M);
                check("memory_req", bus.mem_req, 1);
                if (abort && w == 1) begin
                    reset = 1'b1;
                    bus.start = 1'b0;
                    bus.mem_ready = 1'b0;
                    @(negedge clock);
                    check_reset_vals();
                    reset = 1'b0;
                    m_cc = 3'b100;
                    m_ret = 0;
                    m_stat = 0;
                    return;
                end
                bus.mem_ready = (w == k);
                bus.dmem_error = (w == k) ? derr : 1'($urandom);
            end
        end else begin
            check("memory_en", en(), EN_M);
            check("memory_req_nonmem", bus.mem_req, 0);
            bus.mem_ready = 1'($urandom);
            bus.dmem_error = 1'b0;
        end
        @(negedge clock);
        bus.mem_ready = 1'b0;
        bus.dmem_error = 1'b0;
        if (mem && derr) begin
            m_stat = 2'd2;
            halted = 1;
            bus.start = 1'b0;
            check("derr_en", en(), EN_Z);
            check("derr_stat", bus.stat, 2);
            check("derr_retired", bus.retired, m_ret);
            return;
        end
        check("writeback_en", en(), EN_W);
        check("writeback_stat", bus.stat, 0);
        @(negedge clock);
        check("pcupd_en", en(), EN_P);
        check("pcupd_cnd", bus.cnd, ref_cnd(ic, fn, m_cc));
        bus.start = 1'b0;
        @(negedge clock);
        m_ret++;
        check("retired", bus.retired, m_ret);
    endtask

    task automatic halted_check();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("halt_en", en(), EN_Z);
            check("halt_stat", bus.stat, m_stat);
            check("halt_busy", bus.busy, 0);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [3:0] ic, fn;
        int r;
        bus.start = 0; bus.icode = 0; bus.ifun = 0; bus.imem_error = 0;
        bus.mem_ready = 0; bus.dmem_error = 0;
        bus.alu_zf = 0; bus.alu_sf = 0; bus.alu_of = 0;
        @(negedge clock);
        do_reset();
        go();
        run_instr(4'h6, 4'h1, 0, 0, 0, 3'b010, 0);
        check("opq_cc", bus.cc, 3'b010);
        run_instr(4'h5, 4'h0, 0, 3, 0, 3'b111, 0);
        run_instr(4'h7, 4'h2, 0, 0, 0, 3'b000, 0);
        run_instr(4'h7, 4'h3, 0, 0, 0, 3'b000, 0);
        run_instr(4'h3, 4'h0, 0, 0, 0, 3'b000, 0);
        run_instr(4'h0, 4'h0, 0, 0, 0, 3'b000, 0);
        halted_check(); do_reset(); go();
        run_instr(4'h6, 4'h5, 0, 0, 0, 3'b000, 0);
        halted_check(); do_reset(); go();
        run_instr(4'h0, 4'h0, 1, 0, 0, 3'b000, 0);
        halted_check(); do_reset(); go();
        run_instr(4'h4, 4'h0, 0, 1, 1, 3'b000, 0);
        halted_check(); do_reset(); go();
        run_instr(4'h8, 4'h0, 0, 4, 0, 3'b000, 1);
        go();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                run_instr(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0), 0, 0, 3'($urandom), 0);
            end else if (r == 1) begin
                run_instr(4'hA, 4'h0, 0, $urandom_range(0, 3), 1, 3'($urandom), 0);
            end else begin
                ic = 4'($urandom_range(1, 11));
                fn = ic == 4'd6 ? 4'($urandom_range(0, 3)) : (ic == 4'd2 || ic == 4'd7) ? 4'($urandom_range(0, 6)) : 4'd0;
                run_instr(ic, fn, 0, $urandom_range(0, 3), 0, 3'($urandom), 0);
            end
            if (halted) begin
                halted_check();
                do_reset();
                go();
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
